// File: rtl/agree_pht.sv
// Agree-predictor pattern history table: 2-bit counters predict agreement with the
// per-branch bias bit, indexed by global history XOR fetch PC, swept to weakly-agree on reset.
module agree_pht #(
  parameter int GHR_WIDTH = 8,
  parameter int PC_LSB    = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  output logic                 o_ready,
  input  logic                 i_lookup_valid,
  input  logic [31:0]          i_lookup_pc,
  input  logic [GHR_WIDTH-1:0] i_ghr,
  input  logic                 i_bias_taken,
  output logic                 o_pred_valid,
  output logic                 o_pred_taken,
  output logic [GHR_WIDTH-1:0] o_pred_idx,
  input  logic                 i_update_valid,
  input  logic [GHR_WIDTH-1:0] i_update_idx,
  input  logic                 i_update_taken,
  input  logic                 i_update_bias
);

  localparam int DEPTH = 1 << GHR_WIDTH;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e               state_q;
  logic [GHR_WIDTH-1:0] ptr_q;
  logic [1:0]           pht_q [DEPTH];

  logic [GHR_WIDTH-1:0] lookup_idx;
  logic [1:0]           upd_cnt;
  logic [1:0]           upd_cnt_d;
  logic [1:0]           look_cnt;
  logic                 upd_en;
  logic                 wr_en;
  logic [GHR_WIDTH-1:0] wr_idx;
  logic [1:0]           wr_data;
  logic                 unused_pc_bits;

  assign unused_pc_bits = ^{i_lookup_pc[31:PC_LSB+GHR_WIDTH], i_lookup_pc[PC_LSB-1:0]};
  assign lookup_idx     = i_ghr ^ i_lookup_pc[PC_LSB +: GHR_WIDTH];
  assign upd_en         = (state_q == ST_RUN) && i_update_valid;

  // Read-modify-write of the counter being trained; saturates at both ends.
  always_comb begin
    upd_cnt   = pht_q[i_update_idx];
    upd_cnt_d = upd_cnt;
    if (i_update_taken == i_update_bias) begin
      if (upd_cnt != 2'b11) upd_cnt_d = upd_cnt + 2'd1;
    end else begin
      if (upd_cnt != 2'b00) upd_cnt_d = upd_cnt - 2'd1;
    end
  end

  // Write-first: a same-cycle update to the looked-up entry is visible to the lookup.
  always_comb begin
    look_cnt = pht_q[lookup_idx];
    if (upd_en && (i_update_idx == lookup_idx)) look_cnt = upd_cnt_d;
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = i_update_idx;
    wr_data = upd_cnt_d;
    if (state_q == ST_INIT) begin
      wr_en   = 1'b1;
      wr_idx  = ptr_q;
      wr_data = 2'b10;
    end else if (i_update_valid) begin
      wr_en = 1'b1;
    end
  end

  // Counter storage carries no reset; the init sweep rewrites every entry.
  always_ff @(posedge i_clk) begin
    if (wr_en) pht_q[wr_idx] <= wr_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_INIT;
      ptr_q        <= '0;
      o_ready      <= 1'b0;
      o_pred_valid <= 1'b0;
      o_pred_taken <= 1'b0;
      o_pred_idx   <= '0;
    end else begin
      o_pred_valid <= 1'b0;
      case (state_q)
        ST_INIT: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == {GHR_WIDTH{1'b1}}) begin
            state_q <= ST_RUN;
            o_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_lookup_valid) begin
            o_pred_valid <= 1'b1;
            o_pred_taken <= look_cnt[1] ? i_bias_taken : ~i_bias_taken;
            o_pred_idx   <= lookup_idx;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_agree_pht.sv
// Scoreboard bench for agree_pht: a counter-table model pushes expected predictions
// when stimulus is driven; they are popped and compared one cycle later.
module tb_agree_pht;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       o_ready;
  logic       i_lookup_valid = 1'b0;
  logic [31:0] i_lookup_pc = '0;
  logic [7:0] i_ghr = '0;
  logic       i_bias_taken = 1'b0;
  logic       o_pred_valid;
  logic       o_pred_taken;
  logic [7:0] o_pred_idx;
  logic       i_update_valid = 1'b0;
  logic [7:0] i_update_idx = '0;
  logic       i_update_taken = 1'b0;
  logic       i_update_bias = 1'b0;

  agree_pht #(.GHR_WIDTH(8), .PC_LSB(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .o_ready(o_ready),
    .i_lookup_valid(i_lookup_valid), .i_lookup_pc(i_lookup_pc), .i_ghr(i_ghr),
    .i_bias_taken(i_bias_taken), .o_pred_valid(o_pred_valid), .o_pred_taken(o_pred_taken),
    .o_pred_idx(o_pred_idx), .i_update_valid(i_update_valid), .i_update_idx(i_update_idx),
    .i_update_taken(i_update_taken), .i_update_bias(i_update_bias)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       v;
    logic       t;
    logic [7:0] idx;
  } exp_t;

  exp_t       exp_q[$];
  int         model_pht[256];
  logic       last_t;
  logic [7:0] last_idx;
  int         tests_run = 0;
  int         tests_failed = 0;
  int         run_cycles = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Drive one cycle of stimulus at posedge+1, push the model's expectation, check after the edge.
  task automatic step(input logic lv, input logic [31:0] pc, input logic [7:0] ghr,
                      input logic bias, input logic uv, input logic [7:0] uidx,
                      input logic ut, input logic ub, input string tag);
    exp_t e;
    exp_t got;
    logic [7:0] idx;
    i_lookup_valid = lv; i_lookup_pc = pc; i_ghr = ghr; i_bias_taken = bias;
    i_update_valid = uv; i_update_idx = uidx; i_update_taken = ut; i_update_bias = ub;
    if (uv) begin
      if (ut == ub) model_pht[uidx] = (model_pht[uidx] == 3) ? 3 : model_pht[uidx] + 1;
      else          model_pht[uidx] = (model_pht[uidx] == 0) ? 0 : model_pht[uidx] - 1;
    end
    idx = ghr ^ pc[9:2];
    if (lv) begin
      last_t   = (model_pht[idx] >= 2) ? bias : ~bias;
      last_idx = idx;
    end
    e = '{v: lv, t: last_t, idx: last_idx};
    exp_q.push_back(e);
    @(posedge i_clk); #1;
    run_cycles++;
    e = exp_q.pop_front();
    got = '{v: o_pred_valid, t: o_pred_taken, idx: o_pred_idx};
    if (lv) check_val(tag, 32'(got), 32'(e));
    else    check_val({tag, "_idle"}, 32'(got), 32'(e));
  endtask

  task automatic init_sweep(input string tag);
    int edges = 0;
    logic saw_valid = 1'b0;
    i_lookup_valid = 1'b1; i_lookup_pc = 32'h10; i_ghr = 8'h00; i_bias_taken = 1'b1;
    i_update_valid = 1'b0;
    i_rst = 1'b0;
    while (edges < 300) begin
      @(posedge i_clk); #1;
      edges++;
      if (o_pred_valid) saw_valid = 1'b1;
      if (o_ready) break;
    end
    check_val({tag, "_ready_edges"}, 32'(edges), 32'd256);
    check_val({tag, "_valid_in_init"}, 32'(saw_valid), 32'd0);
    for (int i = 0; i < 256; i++) model_pht[i] = 2;
    last_t = 1'b0; last_idx = 8'h00;
    run_cycles = 0;
  endtask

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    check_val("rst_ready", 32'(o_ready), 32'd0);
    check_val("rst_outs", {29'd0, o_pred_valid, o_pred_taken, |o_pred_idx}, 32'd0);

    init_sweep("init1");

    step(1, 32'h10, 8'h00, 1, 0, 8'h00, 0, 0, "lk_bias1");
    step(1, 32'h10, 8'h00, 0, 0, 8'h00, 0, 0, "lk_bias0");
    step(0, 32'h0,  8'h00, 0, 0, 8'h00, 0, 0, "hold");
    step(0, 32'h0,  8'h00, 0, 1, 8'h04, 0, 1, "dis1");
    step(0, 32'h0,  8'h00, 0, 1, 8'h04, 0, 1, "dis2");
    step(1, 32'h10, 8'h00, 1, 0, 8'h00, 0, 0, "lk_cnt00");
    step(0, 32'h0,  8'h00, 0, 1, 8'h04, 0, 1, "dis_sat");
    step(1, 32'h10, 8'h00, 1, 0, 8'h00, 0, 0, "lk_still00");
    for (int i = 0; i < 4; i++) step(0, 32'h0, 8'h00, 0, 1, 8'h04, 1, 1, "agree");
    step(1, 32'h10, 8'h00, 1, 0, 8'h00, 0, 0, "lk_cnt11");
    step(0, 32'h0,  8'h00, 0, 1, 8'h04, 1, 0, "dis_from11");
    step(1, 32'h10, 8'h00, 0, 0, 8'h00, 0, 0, "lk_cnt10");
    step(1, 32'h10, 8'h00, 1, 1, 8'h04, 0, 1, "bypass_01");
    step(1, 32'h0,  8'h04, 0, 1, 8'h04, 1, 1, "bypass_10");

    // Mixed traffic over a small index range so updates and lookups collide often.
    for (int i = 0; i < 60; i++) begin
      logic [7:0] g;
      g = 8'($urandom_range(0, 7));
      step($urandom_range(0, 1) == 1, {22'd0, 8'($urandom_range(0, 7)), 2'b00}, g,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, "rand");
    end

    while (run_cycles < 98) step(0, 32'h0, 8'h00, 0, 1, 8'h04, 0, 1, "train_down");
    step(1, 32'h10, 8'h00, 1, 0, 8'h00, 0, 0, "lk_pre_rst");

    i_rst = 1'b1;
    #1;
    check_val("midrun_ready_drop", 32'(o_ready), 32'd0);
    check_val("midrun_valid_drop", 32'(o_pred_valid), 32'd0);
    @(posedge i_clk); #1;
    exp_q.delete();
    init_sweep("init2");
    step(1, 32'h10, 8'h00, 1, 0, 8'h00, 0, 0, "lk_reinit");
    step(1, 32'h10, 8'h00, 0, 0, 8'h00, 0, 0, "lk_reinit_b0");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/agree_pht.md
# agree_pht

Agree-predictor pattern history table that consumes the global history register output and produces the fetch-stage direction prediction. Each 2-bit saturating counter predicts whether the branch will agree with its per-branch bias bit, not taken/not-taken directly. The table is indexed gshare-style (history XOR PC). Updates come from the execute-stage branch resolution, in the same cycle the history register shifts.

## Interface
- GHR_WIDTH, 8, history width; table holds 2**GHR_WIDTH counters
- PC_LSB, 2, lowest PC bit used for indexing (word-aligned fetch)
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  asynchronous, active-high reset
- o_ready  out  1  high once the init sweep is complete
- i_lookup_valid  in  1  fetch lookup request
- i_lookup_pc  in  32  fetch PC
- i_ghr  in  GHR_WIDTH  current global history
- i_bias_taken  in  1  bias bit for this branch, supplied by the BTB
- o_pred_valid  out  1  registered prediction valid
- o_pred_taken  out  1  predicted direction
- o_pred_idx  out  GHR_WIDTH  index used; carried down the pipe for update
- i_update_valid  in  1  resolved-branch update
- i_update_idx  in  GHR_WIDTH  index returned from o_pred_idx
- i_update_taken  in  1  actual outcome
- i_update_bias  in  1  bias bit used at prediction time

## Operation
- Index = i_ghr XOR i_lookup_pc[PC_LSB+GHR_WIDTH-1 : PC_LSB].
- Counter MSB = 1 means agree. Prediction = counter[1] ? i_bias_taken : ~i_bias_taken.
- Update: agree_out = (i_update_taken == i_update_bias).
  - If agree_out, increment, saturating at 2'b11.
  - Otherwise decrement, saturating at 2'b00.
- FSM states:
  - INIT:
    - Sweep pointer writes 2'b10 (weakly agree) to entry ptr each cycle, ptr 0 → 2**GHR_WIDTH-1.
    - After writing the last entry, go to RUN.
    - o_ready = 0.
    - Lookups produce o_pred_valid = 0.
    - Updates are dropped.
  - RUN:
    - o_ready = 1.
    - Lookups and updates are served every cycle; no stalls, no backpressure.
- Simultaneous lookup and update to the same index: write-first bypass. The prediction uses the post-update counter value.
- Lookup and update to different indices in the same cycle are independent.
- Reset:
  - Reset at any time, including mid-sweep or mid-run, forces INIT with ptr = 0.
  - Table contents are re-initialised by the new sweep.
  - Table storage itself is not reset asynchronously; only the FSM, ptr and output registers are.

## Timing
- Reset values:
  - o_ready = 0, o_pred_valid = 0, o_pred_taken = 0, o_pred_idx = 0.
  - State = INIT, ptr = 0.
- Init length:
  - The first rising edge after reset deassertion writes entry 0.
  - o_ready rises on the edge that writes entry 2**GHR_WIDTH-1, i.e. visible after exactly 2**GHR_WIDTH edges (256 at default).
- Lookup latency is 1 cycle. Inputs sampled at edge N give o_pred_valid/o_pred_taken/o_pred_idx after edge N.
- Outputs hold until the next edge.
- Without a new lookup, o_pred_valid = 0 while o_pred_taken and o_pred_idx hold their last values.
- The update write commits at the sampling edge. A lookup at edge N+1 sees an update sampled at edge N.
- Same-cycle lookup and update at the same index are handled by the bypass.
- A lookup sampled on the edge where the FSM leaves INIT is dropped. The first valid prediction comes from a lookup sampled once o_ready = 1.

## Test plan
- Reset release, hold i_lookup_valid = 1:
  - o_ready goes high exactly 256 edges after reset deassertion.
  - o_pred_valid stays 0 until then.
- After ready, lookup pc = 0x0000_0010, ghr = 0x00, bias = 1:
  - Next cycle o_pred_valid = 1, o_pred_taken = 1, o_pred_idx = 0x04.
  - Repeat with bias = 0 → o_pred_taken = 0.
- Two updates idx = 0x04, taken = 0, bias = 1 (disagree), then lookup idx 0x04 with bias = 1:
  - o_pred_taken = 0 (counter 10→01→00).
  - A third disagree update keeps the counter at 00.
- Four agree updates on idx 0x04 starting from 00, then one disagree:
  - Counter 00→11 saturates, then 10.
  - Prediction equals bias.
- Same-cycle update idx 0x04 (disagree, counter 10→01) and lookup at index 0x04:
  - Prediction reflects 01, o_pred_taken = ~bias.
- Assert i_rst mid-run at 100 cycles after ready:
  - o_ready drops immediately.
  - A fresh 256-cycle sweep runs.
  - Previously trained idx 0x04 reads back weakly agree.
